qbus_slave_seq: RTL

Synchronous QBUS slave-cycle sequencer for the QSIC, clocked by the 20 MHz clk20 domain. It sits directly downstream of the RSYNC address latch and device address-match mux, and upstream of the device register files (switch register, RKV11). It synchronizes the asynchronous QBUS strobes and runs DATI/DATO/DATIO(B) slave handshakes. It drives TRPLY and the Am2908 transceiver controls, and issues one-cycle read/write strobes to the selected device.

---
 rtl/qbus_slave_seq_if.sv | 28 ++
 rtl/qbus_slave_seq.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/qbus_slave_seq_if.sv
// QBUS slave-side signal bundle: raw async bus strobes in, registered replies and device strobes out.
// Latency: none (wires only).
// Backpressure: none beyond the QBUS SYNC/DIN/DOUT/RPLY handshake carried here.
interface qbus_slave_seq_if;
    logic RSYNC;
    logic RDIN;
    logic RDOUT;
    logic RINIT;
    logic addr_match;
    logic TRPLY;
    logic DALtx;
    logic DALbe;
    logic DALst;
    logic rd_stb;
    logic wr_stb;
    logic busy;
    logic err;

    modport slave (
        input  RSYNC, RDIN, RDOUT, RINIT, addr_match,
        output TRPLY, DALtx, DALbe, DALst, rd_stb, wr_stb, busy, err
    );

    modport master (
        output RSYNC, RDIN, RDOUT, RINIT, addr_match,
        input  TRPLY, DALtx, DALbe, DALst, rd_stb, wr_stb, busy, err
    );
endinterface

// File: rtl/qbus_slave_seq.sv
// QBUS DATI/DATO/DATIO(B) slave-cycle sequencer on clk20; reply timeout enabled by QSIC_SLAVE_TIMEOUT_EN.
// Latency: raw strobe +2 sync cycles, then TRPLY +1 on writes and +SETTLE+1 on reads.
// Backpressure: TRPLY held until the master drops its strobe; loss of SYNC aborts immediately.
module qbus_slave_seq #(
    parameter int unsigned SETTLE  = 2,
    parameter logic [7:0]  TIMEOUT = 8'd255
) (
    input  logic            clk20,
    input  logic            reset,
    qbus_slave_seq_if.slave bus
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    typedef enum logic [2:0] {
        IDLE          = 3'd0,
        WAIT_STROBE   = 3'd1,
        RD_SETTLE     = 3'd2,
        RD_REPLY      = 3'd3,
`ifdef QSIC_SLAVE_TIMEOUT_EN
        WAIT_SYNC_END = 3'd5,
`endif
        WR_REPLY      = 3'd4
    } state_t;

    // Two-flop synchronizers: {RINIT, addr_match, RDOUT, RDIN, RSYNC}
    logic [4:0] sync1_q, sync1_d;
    logic [4:0] sync2_q, sync2_d;
    logic       s_rsync, s_rdin, s_rdout, s_rinit, s_match;
    logic       clear;

    always_comb begin
        sync1_d = {bus.RINIT, bus.addr_match, bus.RDOUT, bus.RDIN, bus.RSYNC};
        sync2_d = sync1_q;
    end

    assign {s_rinit, s_match, s_rdout, s_rdin, s_rsync} = sync2_q;
    assign clear = reset | s_rinit;

    always_ff @(posedge clk20) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    state_t     state_q, state_d;
    logic [3:0] settle_q, settle_d;
    logic       busy_q, busy_d;
    logic       trply_q, trply_d;
    logic       daltx_q, daltx_d;
    logic       dalbe_q, dalbe_d;
    logic       dalst_q, dalst_d;
    logic       rd_stb_q, rd_stb_d;
    logic       wr_stb_q, wr_stb_d;

`ifdef QSIC_SLAVE_TIMEOUT_EN
    logic [7:0] tmo_q, tmo_d;
    logic       err_q, err_d;
    logic       tmo_hit;
`else
    logic       unused_timeout;
    assign unused_timeout = ^TIMEOUT;
`endif

    // SYNC loss outranks every other transition, including the timeout.
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
`ifdef QSIC_SLAVE_TIMEOUT_EN
        tmo_hit  = ((state_q == RD_REPLY) || (state_q == WR_REPLY)) && (tmo_q == TIMEOUT);
`endif
        if ((state_q != IDLE) && !s_rsync) begin
            state_d = IDLE;
`ifdef QSIC_SLAVE_TIMEOUT_EN
        end else if (tmo_hit) begin
            state_d = WAIT_SYNC_END;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (s_rsync && s_match) state_d = WAIT_STROBE;
                end
                WAIT_STROBE: begin
                    if (s_rdin) begin
                        state_d  = RD_SETTLE;
                        settle_d = '0;
                    end else if (s_rdout) begin
                        state_d = WR_REPLY;
                    end
                end
                RD_SETTLE: begin
                    settle_d = settle_q + 4'd1;
                    if (settle_q == SETTLE_LAST) state_d = RD_REPLY;
                end
                RD_REPLY: begin
                    if (!s_rdin) state_d = WAIT_STROBE;
                end
                WR_REPLY: begin
                    if (!s_rdout) state_d = WAIT_STROBE;
                end
`ifdef QSIC_SLAVE_TIMEOUT_EN
                WAIT_SYNC_END: state_d = WAIT_SYNC_END;
`endif
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_comb begin
        busy_d   = (state_d != IDLE);
        daltx_d  = (state_d == RD_SETTLE) || (state_d == RD_REPLY);
        dalbe_d  = (state_d == RD_REPLY);
        dalst_d  = (state_d == RD_REPLY);
        trply_d  = (state_d == RD_REPLY) || (state_d == WR_REPLY);
        rd_stb_d = (state_d == RD_REPLY) && (state_q != RD_REPLY);
        wr_stb_d = (state_d == WR_REPLY) && (state_q != WR_REPLY);
    end

    always_ff @(posedge clk20) begin
        if (clear) begin
            state_q  <= IDLE;
            settle_q <= '0;
            busy_q   <= 1'b0;
            trply_q  <= 1'b0;
            daltx_q  <= 1'b0;
            dalbe_q  <= 1'b0;
            dalst_q  <= 1'b0;
            rd_stb_q <= 1'b0;
            wr_stb_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            busy_q   <= busy_d;
            trply_q  <= trply_d;
            daltx_q  <= daltx_d;
            dalbe_q  <= dalbe_d;
            dalst_q  <= dalst_d;
            rd_stb_q <= rd_stb_d;
            wr_stb_q <= wr_stb_d;
        end
    end

`ifdef QSIC_SLAVE_TIMEOUT_EN
    always_comb begin
        tmo_d = tmo_q;
        if ((state_d == RD_REPLY) || (state_d == WR_REPLY)) begin
            tmo_d = (state_d != state_q) ? 8'd0 : tmo_q + 8'd1;
        end
        err_d = err_q | (tmo_hit & s_rsync);
    end

    always_ff @(posedge clk20) begin
        if (clear) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.busy   = busy_q;
    assign bus.TRPLY  = trply_q;
    assign bus.DALtx  = daltx_q;
    assign bus.DALbe  = dalbe_q;
    assign bus.DALst  = dalst_q;
    assign bus.rd_stb = rd_stb_q;
    assign bus.wr_stb = wr_stb_q;

endmodule
